// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Generates same-cycle stall/flush/forward controls and holds the pipeline
// while a multi-cycle MDU operation sits in E, guarded by a watchdog.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow; load-use, redirect and MDU start are evaluated
// MDU_WAIT | multi-cycle MDU op holds E; wait for mdu_done or watchdog
module pipeline_hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rs1_e_i,
  input  logic [4:0]       rs2_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic [4:0]       rd_m_i,
  input  logic [4:0]       rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  input  logic             load_e_i,
  input  logic             pc_src_e_i,
  input  logic             mdu_start_e_i,
  input  logic             mdu_done_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             mdu_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCNT_W = $clog2(MDU_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MDU_TIMEOUT - 1);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic lwstall;
  logic mdustall;
  logic timeout_hit;

  // Forward source for one E operand; M is newer than W so it wins, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Hazard terms shared by the output decode and the FSM.
  always_comb begin
    lwstall     = load_e_i && (rd_e_i != 5'd0) &&
                  ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    timeout_hit = (state_q == MDU_WAIT) && (wcnt_q == WCNT_LAST);
    mdustall    = ((state_q == RUN) && mdu_start_e_i && !mdu_done_i) ||
                  ((state_q == MDU_WAIT) && !mdu_done_i && !timeout_hit);
  end

  // Prioritised stall/flush/forward decode; reset forces bubbles everywhere.
  always_comb begin
    stall_f_o     = 1'b0;
    stall_d_o     = 1'b0;
    stall_e_o     = 1'b0;
    flush_d_o     = 1'b0;
    flush_e_o     = 1'b0;
    flush_m_o     = 1'b0;
    forward_a_e_o = FWD_RF;
    forward_b_e_o = FWD_RF;
    if (!rst_n_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_m_o = 1'b1;
    end else begin
      forward_a_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
      forward_b_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
      if (mdustall) begin
        // The whole front end freezes; E is held so M gets a bubble.
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
        flush_m_o = 1'b1;
      end else if (pc_src_e_i) begin
        // Wrong-path instructions in F/D and D/E are squashed, so a load-use
        // stall on them would be pointless.
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
      end else if (lwstall) begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        flush_e_o = 1'b1;
      end
    end
  end

  // Next-state logic for the MDU hold and its watchdog.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (mdu_start_e_i && !mdu_done_i) begin
          state_d = MDU_WAIT;
          wcnt_d  = '0;
        end
      end
      MDU_WAIT: begin
        if (mdu_done_i) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          // Give up on the MDU: let E advance with whatever it has and flag it.
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM, wait counter and sticky watchdog flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (stall_f_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign mdu_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver applies one directed
// vector per cycle and queues its hand-computed response; the monitor pops
// and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MDU_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic rw_m, rw_w, load_e, pc_src, mdu_start, mdu_done;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  // Field order: stall f/d/e, flush d/e/m, forward a/b, timeout, stall count.
  typedef struct packed {
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    logic to;
    logic [CNT_W-1:0] cnt;
  } resp_t;

  resp_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int failures = 0;
  resp_t act;

  pipeline_hazard_ctrl #(.MDU_TIMEOUT(MDU_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d),
    .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w),
    .reg_write_m_i(rw_m), .reg_write_w_i(rw_w),
    .load_e_i(load_e), .pc_src_e_i(pc_src),
    .mdu_start_e_i(mdu_start), .mdu_done_i(mdu_done),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e),
    .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_m_o(flush_m),
    .forward_a_e_o(fwd_a), .forward_b_e_o(fwd_b),
    .mdu_timeout_o(timeout), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  always_comb act = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                     fwd_a, fwd_b, timeout, stall_cnt};

  function automatic resp_t mk(input logic sf, sd, se, fd, fe, fm,
                               input logic [1:0] fa, fb,
                               input logic to, input int cnt);
    resp_t r;
    r.sf = sf; r.sd = sd; r.se = se;
    r.fd = fd; r.fe = fe; r.fm = fm;
    r.fa = fa; r.fb = fb; r.to = to;
    r.cnt = CNT_W'(cnt);
    return r;
  endfunction

  // Monitor: compare the oldest pending expectation mid-cycle.
  always @(negedge clk) begin
    resp_t e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: actual sf%b sd%b se%b fd%b fe%b fm%b fa=%b fb=%b to=%b cnt=%0d, required sf%b sd%b se%b fd%b fe%b fm%b fa=%b fb=%b to=%b cnt=%0d",
                 n, act.sf, act.sd, act.se, act.fd, act.fe, act.fm, act.fa, act.fb, act.to, act.cnt,
                 e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.fa, e.fb, e.to, e.cnt);
      end
    end
  end

  task automatic step(input string n, input resp_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    rw_m = 1'b0; rw_w = 1'b0; load_e = 1'b0; pc_src = 1'b0;
    mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  // Driver: directed vectors with hand-computed responses.
  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step("rst_outputs", mk(0,0,0,1,1,1,2'b00,2'b00,0,0));
    rst_n = 1'b1;
    step("idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

    load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    step("lw_rs2", mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
    rd_e = 5'd0; rs2_d = 5'd0;
    step("lw_rd0", mk(0,0,0,0,0,0,2'b00,2'b00,0,1));
    rd_e = 5'd9; rs1_d = 5'd9; rs2_d = 5'd3;
    step("lw_rs1", mk(1,1,0,0,1,0,2'b00,2'b00,0,1));
    load_e = 1'b0;
    step("no_load", mk(0,0,0,0,0,0,2'b00,2'b00,0,2));

    clr();
    rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7; rw_m = 1'b1; rw_w = 1'b1;
    step("fwd_m_prio", mk(0,0,0,0,0,0,2'b10,2'b00,0,2));
    rw_m = 1'b0;
    step("fwd_w", mk(0,0,0,0,0,0,2'b01,2'b00,0,2));
    rw_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3; rs2_e = 5'd7;
    step("fwd_ab", mk(0,0,0,0,0,0,2'b10,2'b01,0,2));
    rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    step("fwd_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0,2));

    clr();
    pc_src = 1'b1; load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    step("br_over_lw", mk(0,0,0,1,1,0,2'b00,2'b00,0,2));
    load_e = 1'b0;
    step("br", mk(0,0,0,1,1,0,2'b00,2'b00,0,2));

    clr();
    rst_n = 1'b0;
    step("rst_pre_mdu", mk(0,0,0,1,1,1,2'b00,2'b00,0,0));
    rst_n = 1'b1;
    mdu_start = 1'b1;
    for (int i = 0; i < 10; i++) step("mdu_hold", mk(1,1,1,0,0,1,2'b00,2'b00,0,i));
    mdu_done = 1'b1;
    step("mdu_done", mk(0,0,0,0,0,0,2'b00,2'b00,0,10));
    clr();
    step("after_mdu", mk(0,0,0,0,0,0,2'b00,2'b00,0,10));
    mdu_start = 1'b1; mdu_done = 1'b1;
    step("mdu_1cyc", mk(0,0,0,0,0,0,2'b00,2'b00,0,10));
    clr();
    step("after_1cyc", mk(0,0,0,0,0,0,2'b00,2'b00,0,10));

    mdu_start = 1'b1; pc_src = 1'b1; load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    step("mdu_over_br", mk(1,1,1,0,0,1,2'b00,2'b00,0,10));
    pc_src = 1'b0; load_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0;
    for (int i = 1; i < MDU_TIMEOUT; i++)
      step("to_hold", mk(1,1,1,0,0,1,2'b00,2'b00,0,(10 + i > 15) ? 15 : 10 + i));
    step("to_release", mk(0,0,0,0,0,0,2'b00,2'b00,0,15));
    clr();
    step("to_sticky", mk(0,0,0,0,0,0,2'b00,2'b00,1,15));
    step("to_sticky2", mk(0,0,0,0,0,0,2'b00,2'b00,1,15));
    load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    step("cnt_sat_lw", mk(1,1,0,0,1,0,2'b00,2'b00,1,15));
    clr();
    step("cnt_hold", mk(0,0,0,0,0,0,2'b00,2'b00,1,15));

    mdu_start = 1'b1;
    step("mdu2_run", mk(1,1,1,0,0,1,2'b00,2'b00,1,15));
    step("mdu2_wait", mk(1,1,1,0,0,1,2'b00,2'b00,1,15));
    rst_n = 1'b0;
    step("rst_in_wait", mk(0,0,0,1,1,1,2'b00,2'b00,0,0));
    rst_n = 1'b1; mdu_start = 1'b0;
    step("post_rst", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

    for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: actual pending=%0d, required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives stall and clear of the F/D, D/E and E/M pipeline registers, plus the execute-stage forwarding muxes.
- Detects load-use hazards and taken branches/jumps.
- Holds the pipeline while a multi-cycle M-extension operation (div/rem, multi-cycle mul) occupies E, with a timeout watchdog and a stall-cycle performance counter.

Parameters:
- MDU_TIMEOUT, 64, max cycles spent in MDU_WAIT before forced release (≥2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- rs1_d_i, rs2_d_i  in  5 each  source registers of the instruction in D.
- rs1_e_i, rs2_e_i, rd_e_i  in  5 each  source and destination registers of the instruction in E.
- rd_m_i, rd_w_i  in  5 each  destination registers in M and W.
- reg_write_m_i, reg_write_w_i  in  1 each  writeback enables in M and W.
- load_e_i  in  1  instruction in E is a load (result_src_e == 01).
- pc_src_e_i  in  1  taken branch or jump resolved in E.
- mdu_start_e_i  in  1  multi-cycle MDU op in E, held while E is stalled.
- mdu_done_i  in  1  MDU result valid this cycle.
- stall_f_o, stall_d_o, stall_e_o  out  1 each  hold PC, F/D and D/E registers.
- flush_d_o, flush_e_o, flush_m_o  out  1 each  synchronous clear of F/D, D/E and E/M (drives clr_i).
- forward_a_e_o, forward_b_e_o  out  2 each  00 = regfile, 01 = W result, 10 = M ALU result.
- mdu_timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  CNT_W  count of cycles with stall_f_o = 1, saturating.

Behaviour:
- State: FSM {RUN, MDU_WAIT}, wait counter wcnt (clog2(MDU_TIMEOUT) bits), stall_cnt, sticky timeout flag.
- Reset (rst_n_i low, asynchronous):
  - state = RUN, wcnt = 0, stall_cnt = 0, mdu_timeout_o = 0.
  - Outputs while in reset: all stall_* = 0, flush_d/e/m = 1, forward_* = 00.
  - Reset mid-MDU_WAIT returns to RUN immediately.
- All stall/flush/forward outputs are combinational from state and inputs, so they are same-cycle.
- Forwarding (per operand X ∈ {a: rs1_e, b: rs2_e}):
  - 10 if reg_write_m_i & rd_m_i ≠ 0 & rd_m_i == rsX_e.
  - else 01 if reg_write_w_i & rd_w_i ≠ 0 & rd_w_i == rsX_e.
  - else 00. M has priority over W.
- Term definitions:
  - lwstall = load_e_i & rd_e_i ≠ 0 & (rd_e_i == rs1_d_i | rd_e_i == rs2_d_i).
  - mdustall = (state == RUN & mdu_start_e_i & ~mdu_done_i) | (state == MDU_WAIT & ~mdu_done_i & ~timeout_hit).
  - timeout_hit = (state == MDU_WAIT) & (wcnt == MDU_TIMEOUT-1).
- Outputs, priority highest first:
  - mdustall: stall_f = stall_d = stall_e = 1, flush_m = 1 (bubble into M), flush_d = flush_e = 0. pc_src_e_i and lwstall are ignored.
  - else pc_src_e_i: flush_d = flush_e = 1, stalls = 0. Redirect overrides a coincident lwstall.
  - else lwstall: stall_f = stall_d = 1, flush_e = 1.
  - else all 0.
- FSM transitions:
  - RUN → MDU_WAIT when mdu_start_e_i & ~mdu_done_i; wcnt ← 0.
  - RUN with mdu_start & mdu_done in the same cycle (single-cycle result): no stall, stays in RUN.
  - MDU_WAIT → RUN on mdu_done_i. Stalls drop in that same cycle so E advances with the result.
  - MDU_WAIT, otherwise: wcnt++. On timeout_hit: set mdu_timeout_o (sticky until reset), release stalls that cycle, → RUN.
- stall_cnt: increments every cycle stall_f_o = 1; saturates at all-ones and does not wrap.

Test Plan:
- Load-use: load_e = 1, rd_e = 5, rs2_d = 5 → stall_f = stall_d = flush_e = 1 for one cycle. Repeat with rd_e = 0 → no stall.
- Forward priority: rd_m = rd_w = rs1_e = 7, both write enables high → forward_a = 10. Drop reg_write_m → 01. rs2_e = 0 → forward_b = 00.
- Branch + load-use in the same cycle: pc_src_e = 1 and lwstall true → flush_d = flush_e = 1, stall_f = 0.
- MDU: mdu_start_e high, mdu_done arrives 10 cycles later → stall_e/flush_m high for cycles 0–9, low on cycle 10, stall_cnt = 10, state back to RUN. mdu_start & mdu_done together → no stall.
- Timeout: MDU_TIMEOUT = 4, mdu_done never asserted → stalls high for 4 cycles (RUN cycle + 3 wait), mdu_timeout_o = 1 and stays set, pipeline released.
- Async reset during MDU_WAIT: rst_n_i low mid-cycle → state RUN, stall_cnt = 0, flush_d/e/m = 1 immediately. After release, stall_cnt saturates at 2^CNT_W-1 when forced (CNT_W = 4 → holds 15).
